datapath_unit: RTL and testbench
================================

DATAPATH_UNIT -- requirements
Module: datapath_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, result width; fixed at 16 for this revision.
REQ-002 SHALL have parameter OPW, default 4, opcode width.
REQ-003 SHALL have port clk  input  1  sole clock, all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port enable  input  1  request from controller, held high until done is seen.
REQ-006 SHALL have port opcode  input  OPW  operation select: 0 ADD, 1 SUB, 2 MUL, 3 DIV.
REQ-007 SHALL have ports a, b  input  8 each  unsigned operands.
REQ-008 SHALL have port done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port result  output  WIDTH  operation result, held until the next done.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port div_by_zero  output  1  error flag for DIV with b=0, valid with done.
REQ-012 SHALL have port bad_op  output  1  flag for opcode >= 4, valid with done.

Function
REQ-013 SHALL implement states IDLE, EXEC, DONE, WAIT_LOW.
REQ-014 In IDLE, when enable=1 at a rising edge (edge E0), SHALL latch opcode, a and b, clear the iteration counter, and go to EXEC; operand inputs are ignored at all other times.
REQ-015 ADD SHALL compute {8'h00,a}+{8'h00,b}, SUB SHALL compute {8'h00,a}-{8'h00,b} modulo 2^16; both complete in one EXEC cycle.
REQ-016 MUL SHALL be iterative shift-add, one multiplier bit per cycle, LSB first, 8 EXEC cycles; result is the full 16-bit product.
REQ-017 DIV SHALL be iterative restoring division, 8 EXEC cycles; result[15:8]=remainder, result[7:0]=quotient.
REQ-018 DIV with latched b=0 SHALL skip iteration, complete in one EXEC cycle, give result=16'hFFFF, and set div_by_zero=1.
REQ-019 Opcode >= 4 SHALL complete in one EXEC cycle with result=16'h0000 and bad_op=1.
REQ-020 On the final EXEC edge SHALL register result, div_by_zero and bad_op, and enter DONE; done=1 only while in DONE.
REQ-021 Latency: done SHALL go high after edge E0+1 for ADD, SUB, DIV-by-zero and bad opcode, and after edge E0+8 for MUL and DIV.
REQ-022 From DONE SHALL go to WAIT_LOW if enable=1, else to IDLE, so done lasts exactly one cycle.
REQ-023 In WAIT_LOW SHALL stay until enable=0, then go to IDLE; no new operation is accepted until enable has been low for at least one edge.
REQ-024 Enable dropping during EXEC SHALL NOT abort the operation; the operation completes, done pulses, and the FSM returns to IDLE.
REQ-025 result, div_by_zero and bad_op SHALL change only on the edge that enters DONE; flags clear on a successful operation.
REQ-026 Iteration counter SHALL be 4 bits, reach 7 on the final MUL/DIV iteration, and never wrap during an operation.

Reset
REQ-027 When reset=0, SHALL immediately (without waiting for clk) force IDLE, done=0, busy=0, result=16'h0000, div_by_zero=0, bad_op=0, and clear all internal registers.
REQ-028 Reset asserted mid-operation SHALL discard the operation; no done pulse for it after release.
REQ-029 After reset release, the first rising edge with enable=1 SHALL start a new operation.

Verification
REQ-030 ADD a=8'h7F b=8'h01, enable held -> done high after E0+1 only, result=16'h0080, flags 0, WAIT_LOW until enable drops.
REQ-031 SUB a=8'h03 b=8'h05 -> result=16'hFFFE after E0+1; MUL a=8'hFF b=8'hFF -> result=16'hFE01, done after E0+8, busy high for 9 cycles.
REQ-032 DIV a=8'd200 b=8'd7 -> result=16'h041C after E0+8; DIV a=8'd9 b=0 -> result=16'hFFFF, div_by_zero=1 after E0+1.
REQ-033 opcode=4'h9 -> bad_op=1, result=16'h0000, done after E0+1; next valid ADD 1+1 -> result=16'h0002, bad_op=0.
REQ-034 Assert reset=0 between clock edges during MUL iteration 4 -> outputs zero immediately, no done after release; next ADD 2+2 -> result=16'h0004.
REQ-035 Hold enable high through two done cycles -> exactly one done pulse and one operation; back-to-back operation accepted only after enable low for one edge.

Source files
------------

// File: rtl/datapath_unit.sv
// Multi-cycle arithmetic unit: ADD/SUB in one cycle, MUL by shift-add and
// DIV by restoring division over 8 cycles, with a controller handshake FSM.
module datapath_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OPW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [OPW-1:0]   opcode,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             div_by_zero,
    output logic             bad_op
);

    localparam int unsigned DW = 8;
    localparam int unsigned RW = 16;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0]  LAST_ITER = CW'(7);
    localparam logic [OPW-1:0] OP_ADD    = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB    = OPW'(1);
    localparam logic [OPW-1:0] OP_MUL    = OPW'(2);
    localparam logic [OPW-1:0] OP_DIV    = OPW'(3);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE,
        S_WAIT_LOW
    } state_t;

    state_t           r_state;
    logic [OPW-1:0]   r_op;
    logic [DW-1:0]    r_a;
    logic [DW-1:0]    r_b;
    logic [CW-1:0]    r_cnt;
    logic [RW-1:0]    r_acc;
    logic [RW-1:0]    r_mcand;
    logic [DW-1:0]    r_mplier;
    logic [DW-1:0]    r_rem;
    logic [DW-1:0]    r_quo;
    logic [WIDTH-1:0] r_result;
    logic             r_done;
    logic             r_busy;
    logic             r_dbz;
    logic             r_bad;

    logic [RW-1:0]    w_mul_acc;
    logic [DW:0]      w_div_shift;
    logic             w_div_ge;
    logic [DW-1:0]    w_div_diff;
    logic [DW-1:0]    w_div_rem;
    logic [DW-1:0]    w_div_quo;
    logic             w_last;
    logic [RW-1:0]    w_fin_result;
    logic             w_fin_dbz;
    logic             w_fin_bad;

    // One shift-add / restoring-division step plus the completion value
    always_comb begin
        w_mul_acc    = r_acc;
        w_div_shift  = {r_rem, r_quo[DW-1]};
        w_div_ge     = 1'b0;
        w_div_diff   = '0;
        w_div_rem    = '0;
        w_div_quo    = '0;
        w_last       = 1'b1;
        w_fin_result = '0;
        w_fin_dbz    = 1'b0;
        w_fin_bad    = 1'b0;

        if (r_mplier[0]) begin
            w_mul_acc = r_acc + r_mcand;
        end

        w_div_ge   = (w_div_shift >= {1'b0, r_b});
        w_div_diff = DW'(w_div_shift - {1'b0, r_b});
        if (w_div_ge) begin
            w_div_rem = w_div_diff;
            w_div_quo = {r_quo[DW-2:0], 1'b1};
        end else begin
            w_div_rem = w_div_shift[DW-1:0];
            w_div_quo = {r_quo[DW-2:0], 1'b0};
        end

        case (r_op)
            OP_ADD: w_fin_result = {8'h00, r_a} + {8'h00, r_b};
            OP_SUB: w_fin_result = {8'h00, r_a} - {8'h00, r_b};
            OP_MUL: begin
                w_last       = (r_cnt == LAST_ITER);
                w_fin_result = w_mul_acc;
            end
            OP_DIV: begin
                if (r_b == '0) begin
                    w_fin_result = 16'hFFFF;
                    w_fin_dbz    = 1'b1;
                end else begin
                    w_last       = (r_cnt == LAST_ITER);
                    w_fin_result = {w_div_rem, w_div_quo};
                end
            end
            default: w_fin_bad = 1'b1;
        endcase
    end

    // Handshake FSM with iteration registers and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_dbz    <= 1'b0;
            r_bad    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_op     <= opcode;
                        r_a      <= a;
                        r_b      <= b;
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_mcand  <= {8'h00, a};
                        r_mplier <= b;
                        r_rem    <= '0;
                        r_quo    <= a;
                        r_busy   <= 1'b1;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_last) begin
                        r_result <= WIDTH'(w_fin_result);
                        r_dbz    <= w_fin_dbz;
                        r_bad    <= w_fin_bad;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_acc    <= w_mul_acc;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_rem    <= w_div_rem;
                        r_quo    <= w_div_quo;
                        r_cnt    <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_done <= 1'b0;
                    if (enable) begin
                        r_state <= S_WAIT_LOW;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT_LOW: begin
                    if (!enable) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign done        = r_done;
    assign result      = r_result;
    assign busy        = r_busy;
    assign div_by_zero = r_dbz;
    assign bad_op      = r_bad;

endmodule

// File: tb/tb_datapath_unit.sv
// Self-checking bench for datapath_unit: directed cases, handshake corner
// cases, mid-operation reset and randomized operations against a reference model.
module tb_datapath_unit;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [3:0]  opcode;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        done;
    logic [15:0] result;
    logic        busy;
    logic        div_by_zero;
    logic        bad_op;

    int checks = 0;
    int errors = 0;

    datapath_unit #(.WIDTH(16), .OPW(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .opcode      (opcode),
        .a           (a),
        .b           (b),
        .done        (done),
        .result      (result),
        .busy        (busy),
        .div_by_zero (div_by_zero),
        .bad_op      (bad_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain arithmetic on the operation definitions
    task automatic model(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                         output logic [15:0] r, output logic dbz, output logic bad,
                         output int lat);
        int unsigned xi = x;
        int unsigned yi = y;
        r = 16'h0000; dbz = 1'b0; bad = 1'b0; lat = 1;
        case (op)
            4'd0: r = 16'((xi + yi) % 65536);
            4'd1: r = 16'((xi + 65536 - yi) % 65536);
            4'd2: begin r = 16'(xi * yi); lat = 8; end
            4'd3: begin
                if (yi == 0) begin r = 16'hFFFF; dbz = 1'b1; end
                else begin r = 16'(((xi % yi) * 256) + (xi / yi)); lat = 8; end
            end
            default: bad = 1'b1;
        endcase
    endtask

    // Launch one operation and watch for done; k counts negedges after E0 (0 = right after E0)
    task automatic run_op(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                          input bit release_en, input int drop_k,
                          output int lat, output logic [15:0] res, output logic dbz,
                          output logic bad, output int busy_cnt);
        @(negedge clk);
        enable = 1'b1; opcode = op; a = x; b = y;
        @(posedge clk);
        #1;
        opcode = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
        lat = -1; res = 16'h0000; dbz = 1'b0; bad = 1'b0; busy_cnt = 0;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                lat = k; res = result; dbz = div_by_zero; bad = bad_op;
            end
            if (k == drop_k) enable = 1'b0;
        end
        if (release_en) enable = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; opcode = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({done, busy, div_by_zero, bad_op, result} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 00000", {done, busy, div_by_zero, bad_op, result});
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy=%b done=%b exp 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [3:0]  ops [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd9, 4'd0};
        logic [7:0]  xs  [7] = '{8'h7F, 8'h03, 8'hFF, 8'd200, 8'd9, 8'h12, 8'h01};
        logic [7:0]  ys  [7] = '{8'h01, 8'h05, 8'hFF, 8'd7, 8'd0, 8'h34, 8'h01};
        logic [15:0] rs  [7] = '{16'h0080, 16'hFFFE, 16'hFE01, 16'h041C, 16'hFFFF, 16'h0000, 16'h0002};
        logic        zs  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        bs  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int          ls  [7] = '{1, 1, 8, 8, 1, 1, 1};
        int lat, bc;
        logic [15:0] res;
        logic dbz, bad;
        for (int i = 0; i < 7; i++) begin
            run_op(ops[i], xs[i], ys[i], 1'b1, -1, lat, res, dbz, bad, bc);
            checks++;
            if (lat !== ls[i] || res !== rs[i] || dbz !== zs[i] || bad !== bs[i]) begin
                errors++;
                $display("FAIL directed_%0d got lat=%0d res=%h dbz=%b bad=%b exp lat=%0d res=%h dbz=%b bad=%b",
                         i, lat, res, dbz, bad, ls[i], rs[i], zs[i], bs[i]);
            end
            if (ops[i] == 4'd2) begin
                checks++;
                if (bc !== 9) begin
                    errors++;
                    $display("FAIL mul_busy_cycles got %0d exp 9", bc);
                end
            end
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL directed_%0d_idle busy=%b done=%b exp 0 0", i, busy, done);
            end
        end
    endtask

    // Enable held past done: single pulse, WAIT_LOW, then back-to-back after one low edge
    task automatic test_back_to_back();
        int lat, bc, extra_done;
        logic [15:0] res;
        logic dbz, bad;
        run_op(4'd0, 8'h7F, 8'h01, 1'b0, -1, lat, res, dbz, bad, bc);
        checks++;
        if (lat !== 1 || res !== 16'h0080 || dbz !== 1'b0 || bad !== 1'b0) begin
            errors++;
            $display("FAIL hold_add got lat=%0d res=%h exp lat=1 res=0080", lat, res);
        end
        opcode = 4'd0; a = 8'h11; b = 8'h22;
        extra_done = 0; bc = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done === 1'b1) extra_done++;
            if (busy === 1'b1) bc++;
        end
        checks++;
        if (extra_done !== 0 || bc !== 6 || result !== 16'h0080) begin
            errors++;
            $display("FAIL wait_low got extra_done=%0d busy_cnt=%0d res=%h exp 0 6 0080",
                     extra_done, bc, result);
        end
        enable = 1'b0;
        run_op(4'd1, 8'h50, 8'h10, 1'b1, -1, lat, res, dbz, bad, bc);
        checks++;
        if (lat !== 1 || res !== 16'h0040) begin
            errors++;
            $display("FAIL back_to_back got lat=%0d res=%h exp lat=1 res=0040", lat, res);
        end
        @(negedge clk);
    endtask

    task automatic test_enable_drop();
        int lat, bc;
        logic [15:0] res;
        logic dbz, bad;
        run_op(4'd3, 8'd250, 8'd13, 1'b1, 2, lat, res, dbz, bad, bc);
        checks++;
        if (lat !== 8 || res !== 16'h0313 || dbz !== 1'b0) begin
            errors++;
            $display("FAIL enable_drop got lat=%0d res=%h dbz=%b exp lat=8 res=0313 dbz=0", lat, res, dbz);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL enable_drop_idle busy=%b exp 0", busy);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, bc, seen_done, seen_busy;
        logic [15:0] res;
        logic dbz, bad;
        run_op(4'd0, 8'h10, 8'h20, 1'b1, -1, lat, res, dbz, bad, bc);
        @(negedge clk);
        enable = 1'b1; opcode = 4'd2; a = 8'hFF; b = 8'hFF;
        @(posedge clk);
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || result !== 16'h0030) begin
            errors++;
            $display("FAIL pre_reset busy=%b res=%h exp 1 0030", busy, result);
        end
        #2 reset = 1'b0; enable = 1'b0;
        #1;
        checks++;
        if ({done, busy, div_by_zero, bad_op, result} !== 20'h0) begin
            errors++;
            $display("FAIL async_reset got %h exp 00000", {done, busy, div_by_zero, bad_op, result});
        end
        #1 reset = 1'b1;
        seen_done = 0; seen_busy = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
            if (busy === 1'b1) seen_busy++;
        end
        checks++;
        if (seen_done !== 0 || seen_busy !== 0) begin
            errors++;
            $display("FAIL post_reset got done=%0d busy=%0d exp 0 0", seen_done, seen_busy);
        end
        run_op(4'd0, 8'h02, 8'h02, 1'b1, -1, lat, res, dbz, bad, bc);
        checks++;
        if (lat !== 1 || res !== 16'h0004) begin
            errors++;
            $display("FAIL after_reset_add got lat=%0d res=%h exp lat=1 res=0004", lat, res);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int lat, bc, elat;
        logic [15:0] res, eres;
        logic dbz, bad, edbz, ebad;
        logic [3:0] op;
        logic [7:0] x, y;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) op = 4'($urandom_range(0, 3));
            x = 8'($urandom);
            y = 8'($urandom);
            if ($urandom_range(0, 7) == 0) y = 8'h00;
            model(op, x, y, eres, edbz, ebad, elat);
            run_op(op, x, y, 1'b1, -1, lat, res, dbz, bad, bc);
            checks++;
            if (lat !== elat || res !== eres || dbz !== edbz || bad !== ebad || bc !== elat + 1) begin
                errors++;
                $display("FAIL random_%0d op=%0d a=%h b=%h got lat=%0d res=%h dbz=%b bad=%b busy=%0d exp lat=%0d res=%h dbz=%b bad=%b",
                         i, op, x, y, lat, res, dbz, bad, bc, elat, eres, edbz, ebad);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_op();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
